// File: rtl/lis3dh_poller.sv
// lis3dh_poller: sequences spi_master transactions to identify, configure and periodically sample a LIS3DH.
// Define LIS3DH_POLL_STATUS_EN to gate every round on STATUS_REG.ZYXDA before the axis reads.
module lis3dh_poller #(
  parameter int unsigned PERIOD_CYCLES = 1000,
  parameter logic [7:0]  CTRL_REG1_VAL = 8'h57
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        spi_request,
  output logic [4:0]  spi_nbits,
  output logic [31:0] spi_mosi_data,
  input  logic [31:0] spi_miso_data,
  input  logic        spi_ready,
  output logic [15:0] sample_x,
  output logic [15:0] sample_y,
  output logic [15:0] sample_z,
  output logic        sample_valid,
  output logic        id_ok,
  output logic        fault
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WHOAMI,
    ST_INIT,
`ifdef LIS3DH_POLL_STATUS_EN
    ST_STATUS,
`endif
    ST_RD_X,
    ST_RD_Y,
    ST_RD_Z,
    ST_PUBLISH,
    ST_WAIT_PERIOD,
    ST_FAULT
  } state_t;

  typedef enum logic [1:0] {
    PH_ISSUE,
    PH_WAIT_BUSY,
    PH_WAIT_DONE
  } phase_t;

  localparam logic [19:0] PERIOD_LOAD = 20'(PERIOD_CYCLES - 1);

`ifdef LIS3DH_POLL_STATUS_EN
  localparam state_t FIRST_READ = ST_STATUS;
`else
  localparam state_t FIRST_READ = ST_RD_X;
`endif

  state_t      state_q, state_d;
  phase_t      phase_q, phase_d;
  logic [15:0] wd_q, wd_d;
  logic [19:0] period_q, period_d;
  logic        spi_request_q, spi_request_d;
  logic [4:0]  spi_nbits_q, spi_nbits_d;
  logic [31:0] spi_mosi_q, spi_mosi_d;
  logic [15:0] shadow_x_q, shadow_x_d;
  logic [15:0] shadow_y_q, shadow_y_d;
  logic [15:0] sample_x_q, sample_x_d;
  logic [15:0] sample_y_q, sample_y_d;
  logic [15:0] sample_z_q, sample_z_d;
  logic        sample_valid_q, sample_valid_d;
  logic        id_ok_q, id_ok_d;
  logic        fault_q, fault_d;

  logic [4:0]  tx_nbits;
  logic [31:0] tx_mosi;
  logic [15:0] axis_val;
  logic        unused_miso_hi;

  assign unused_miso_hi = ^spi_miso_data[31:16];
  assign axis_val       = {spi_miso_data[7:0], spi_miso_data[15:8]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      phase_q        <= PH_ISSUE;
      wd_q           <= '0;
      period_q       <= '0;
      spi_request_q  <= 1'b0;
      spi_nbits_q    <= '0;
      spi_mosi_q     <= '0;
      shadow_x_q     <= '0;
      shadow_y_q     <= '0;
      sample_x_q     <= '0;
      sample_y_q     <= '0;
      sample_z_q     <= '0;
      sample_valid_q <= 1'b0;
      id_ok_q        <= 1'b0;
      fault_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      wd_q           <= wd_d;
      period_q       <= period_d;
      spi_request_q  <= spi_request_d;
      spi_nbits_q    <= spi_nbits_d;
      spi_mosi_q     <= spi_mosi_d;
      shadow_x_q     <= shadow_x_d;
      shadow_y_q     <= shadow_y_d;
      sample_x_q     <= sample_x_d;
      sample_y_q     <= sample_y_d;
      sample_z_q     <= sample_z_d;
      sample_valid_q <= sample_valid_d;
      id_ok_q        <= id_ok_d;
      fault_q        <= fault_d;
    end
  end

  always_comb begin
    tx_nbits = 5'd0;
    tx_mosi  = 32'h0;
    case (state_q)
      ST_WHOAMI: begin tx_nbits = 5'd15; tx_mosi = 32'h0000_8F00; end
      ST_INIT:   begin tx_nbits = 5'd15; tx_mosi = {16'h0, 8'h20, CTRL_REG1_VAL}; end
`ifdef LIS3DH_POLL_STATUS_EN
      ST_STATUS: begin tx_nbits = 5'd15; tx_mosi = 32'h0000_A700; end
`endif
      ST_RD_X:   begin tx_nbits = 5'd23; tx_mosi = 32'h00E8_0000; end
      ST_RD_Y:   begin tx_nbits = 5'd23; tx_mosi = 32'h00EA_0000; end
      ST_RD_Z:   begin tx_nbits = 5'd23; tx_mosi = 32'h00EC_0000; end
      default:   begin tx_nbits = 5'd0;  tx_mosi = 32'h0; end
    endcase
  end

  // Transaction states share the ISSUE/WAIT_BUSY/WAIT_DONE walk; only the completion action differs.
  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q;
    wd_d           = wd_q;
    period_d       = period_q;
    spi_request_d  = 1'b0;
    spi_nbits_d    = spi_nbits_q;
    spi_mosi_d     = spi_mosi_q;
    shadow_x_d     = shadow_x_q;
    shadow_y_d     = shadow_y_q;
    sample_x_d     = sample_x_q;
    sample_y_d     = sample_y_q;
    sample_z_d     = sample_z_q;
    sample_valid_d = 1'b0;
    id_ok_d        = id_ok_q;
    fault_d        = fault_q;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_WHOAMI;
          phase_d = PH_ISSUE;
          id_ok_d = 1'b0;
        end
      end

      ST_PUBLISH: begin
        state_d  = ST_WAIT_PERIOD;
        period_d = PERIOD_LOAD;
      end

      ST_WAIT_PERIOD: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (period_q == 20'd0) begin
          state_d = FIRST_READ;
          phase_d = PH_ISSUE;
        end else begin
          period_d = period_q - 20'd1;
        end
      end

      ST_FAULT: begin
        state_d = ST_FAULT;
      end

      default: begin
        case (phase_q)
          PH_ISSUE: begin
            spi_request_d = 1'b1;
            spi_nbits_d   = tx_nbits;
            spi_mosi_d    = tx_mosi;
            wd_d          = 16'd0;
            phase_d       = PH_WAIT_BUSY;
          end

          PH_WAIT_BUSY: begin
            if (!spi_ready) begin
              phase_d = PH_WAIT_DONE;
              wd_d    = wd_q + 16'd1;
            end else if (wd_q == 16'hFFFF) begin
              state_d = ST_FAULT;
              fault_d = 1'b1;
            end else begin
              wd_d = wd_q + 16'd1;
            end
          end

          PH_WAIT_DONE: begin
            if (spi_ready) begin
              phase_d = PH_ISSUE;
              case (state_q)
                ST_WHOAMI: begin
                  if (spi_miso_data[7:0] == 8'h33) begin
                    id_ok_d = 1'b1;
                    state_d = enable ? ST_INIT : ST_IDLE;
                  end else begin
                    state_d = ST_FAULT;
                    fault_d = 1'b1;
                  end
                end
                ST_INIT: begin
                  state_d  = enable ? ST_WAIT_PERIOD : ST_IDLE;
                  period_d = PERIOD_LOAD;
                end
`ifdef LIS3DH_POLL_STATUS_EN
                ST_STATUS: begin
                  if (!enable) begin
                    state_d = ST_IDLE;
                  end else if (spi_miso_data[3]) begin
                    state_d = ST_RD_X;
                  end else begin
                    state_d  = ST_WAIT_PERIOD;
                    period_d = PERIOD_LOAD;
                  end
                end
`endif
                ST_RD_X: begin
                  shadow_x_d = axis_val;
                  state_d    = enable ? ST_RD_Y : ST_IDLE;
                end
                ST_RD_Y: begin
                  shadow_y_d = axis_val;
                  state_d    = enable ? ST_RD_Z : ST_IDLE;
                end
                // Z goes straight to the output so all three axes appear in the PUBLISH cycle.
                ST_RD_Z: begin
                  if (enable) begin
                    sample_x_d     = shadow_x_q;
                    sample_y_d     = shadow_y_q;
                    sample_z_d     = axis_val;
                    sample_valid_d = 1'b1;
                    state_d        = ST_PUBLISH;
                  end else begin
                    state_d = ST_IDLE;
                  end
                end
                default: state_d = ST_IDLE;
              endcase
            end else if (wd_q == 16'hFFFF) begin
              state_d = ST_FAULT;
              fault_d = 1'b1;
            end else begin
              wd_d = wd_q + 16'd1;
            end
          end

          default: phase_d = PH_ISSUE;
        endcase
      end
    endcase
  end

  assign spi_request   = spi_request_q;
  assign spi_nbits     = spi_nbits_q;
  assign spi_mosi_data = spi_mosi_q;
  assign sample_x      = sample_x_q;
  assign sample_y      = sample_y_q;
  assign sample_z      = sample_z_q;
  assign sample_valid  = sample_valid_q;
  assign id_ok         = id_ok_q;
  assign fault         = fault_q;

endmodule
